// File: rtl/tictactoe_turn_controller.sv
// Tic-tac-toe turn sequencer: owns both board bitmaps, alternates turns, runs the per-turn
// countdown, validates and applies moves, auto-plays on timeout and detects win/tie.
module tictactoe_turn_controller #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned TURN_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic [3:0] rand_pos,
  output logic       player,
  output logic [4:0] time_left,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       invalid_move,
  output logic       print_sprite,
  output logic [3:0] sprite_pos,
  output logic       sprite_player,
  output logic       auto_played,
  output logic       print_win,
  output logic [1:0] winner
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [4:0] TimeInit = 5'(TURN_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StWaitMove, StValidate, StApply, StCheckWin, StGameOver
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        board_x_q, board_x_d, board_o_q, board_o_d;
  logic              player_q, player_d;
  logic [4:0]        time_left_q, time_left_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [3:0]        pos_q, pos_d;
  logic              auto_q, auto_d;
  logic [3:0]        last_pos_q, last_pos_d;
  logic              last_player_q, last_player_d;
  logic [1:0]        winner_q, winner_d;

  logic [8:0]  occupied;
  logic [15:0] occupied_ext;
  logic        reject;
  logic        tick;
  logic [3:0]  auto_pos;
  logic        auto_found;

  assign occupied     = board_x_q | board_o_q;
  assign occupied_ext = {7'b0, occupied};
  // Out-of-range cells read as zero in occupied_ext, so the range test is separate.
  assign reject       = (pos_q > 4'd8) || occupied_ext[pos_q];
  assign tick         = (presc_q == PrescMax);

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Timeout target: first free cell scanning upward from rand_pos, wrapping 8 -> 0.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    auto_pos   = '0;
    auto_found = 1'b0;
    base       = (rand_pos > 4'd8) ? 32'd0 : 32'(rand_pos);
    for (int unsigned i = 0; i < 9; i++) begin
      idx = (base + i) % 9;
      if (!auto_found && !occupied[idx[3:0]]) begin
        auto_pos   = idx[3:0];
        auto_found = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      board_x_q     <= '0;
      board_o_q     <= '0;
      player_q      <= 1'b0;
      time_left_q   <= TimeInit;
      presc_q       <= '0;
      pos_q         <= '0;
      auto_q        <= 1'b0;
      last_pos_q    <= '0;
      last_player_q <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      board_x_q     <= board_x_d;
      board_o_q     <= board_o_d;
      player_q      <= player_d;
      time_left_q   <= time_left_d;
      presc_q       <= presc_d;
      pos_q         <= pos_d;
      auto_q        <= auto_d;
      last_pos_q    <= last_pos_d;
      last_player_q <= last_player_d;
      winner_q      <= winner_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    board_x_d     = board_x_q;
    board_o_d     = board_o_q;
    player_d      = player_q;
    time_left_d   = time_left_q;
    presc_d       = presc_q;
    pos_d         = pos_q;
    auto_d        = auto_q;
    last_pos_d    = last_pos_q;
    last_player_d = last_player_q;
    winner_d      = winner_q;
    case (state_q)
      StIdle, StGameOver: begin
        if (start) begin
          board_x_d   = '0;
          board_o_d   = '0;
          winner_d    = 2'b00;
          player_d    = 1'b0;
          time_left_d = TimeInit;
          presc_d     = '0;
          state_d     = StWaitMove;
        end
      end
      StWaitMove: begin
        // A submitted move freezes the countdown that cycle, so a coincident timeout is lost.
        if (move_valid) begin
          pos_d   = move_pos;
          auto_d  = 1'b0;
          state_d = StValidate;
        end else begin
          presc_d = tick ? '0 : presc_q + PrescW'(1);
          if (tick) begin
            time_left_d = time_left_q - 5'd1;
            if (time_left_q == 5'd1) begin
              pos_d   = auto_pos;
              auto_d  = 1'b1;
              state_d = StApply;
            end
          end
        end
      end
      StValidate: state_d = reject ? StWaitMove : StApply;
      StApply: begin
        if (player_q) board_o_d = board_o_q | (9'b1 << pos_q);
        else          board_x_d = board_x_q | (9'b1 << pos_q);
        last_pos_d    = pos_q;
        last_player_d = player_q;
        state_d       = StCheckWin;
      end
      StCheckWin: begin
        if (has_line(player_q ? board_o_q : board_x_q)) begin
          winner_d = player_q ? 2'b10 : 2'b01;
          state_d  = StGameOver;
        end else if (&occupied) begin
          winner_d = 2'b11;
          state_d  = StGameOver;
        end else begin
          player_d    = ~player_q;
          time_left_d = TimeInit;
          presc_d     = '0;
          state_d     = StWaitMove;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pulses decoded from state, sprite fields track the most recent placement.
  always_comb begin
    player        = player_q;
    time_left     = time_left_q;
    board_x       = board_x_q;
    board_o       = board_o_q;
    winner        = winner_q;
    invalid_move  = (state_q == StValidate) && reject;
    print_sprite  = (state_q == StApply);
    auto_played   = (state_q == StApply) && auto_q;
    print_win     = (state_q == StGameOver);
    sprite_pos    = (state_q == StApply) ? pos_q : last_pos_q;
    sprite_player = (state_q == StApply) ? player_q : last_player_q;
  end

endmodule

// File: tb/tb_tictactoe_turn_controller.sv
// Self-checking bench for tictactoe_turn_controller with TICK_DIV=4, TURN_TIMEOUT=3.
module tb_tictactoe_turn_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic [3:0] rand_pos = 4'd0;
  logic       player;
  logic [4:0] time_left;
  logic [8:0] board_x, board_o;
  logic       invalid_move, print_sprite, sprite_player, auto_played, print_win;
  logic [3:0] sprite_pos;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];  // {pos, player, auto}
  logic [5:0] exp_e;
  logic       exp_player = 1'b0;

  always #5 clk = ~clk;

  tictactoe_turn_controller #(.TICK_DIV(4), .TURN_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_pos(move_pos),
    .rand_pos(rand_pos), .player(player), .time_left(time_left), .board_x(board_x),
    .board_o(board_o), .invalid_move(invalid_move), .print_sprite(print_sprite),
    .sprite_pos(sprite_pos), .sprite_player(sprite_player), .auto_played(auto_played),
    .print_win(print_win), .winner(winner)
  );

  // Scoreboard: every placement pulse must match the oldest expected placement.
  always @(negedge clk) begin
    if (print_sprite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sprite_unexpected: got pos=%0d player=%0d auto=%0d, required none",
                 sprite_pos, sprite_player, auto_played);
      end else begin
        exp_e = exp_q.pop_front();
        if ({sprite_pos, sprite_player, auto_played} !== exp_e) begin
          errors++;
          $display("FAIL sprite: got pos=%0d player=%0d auto=%0d, required pos=%0d player=%0d auto=%0d",
                   sprite_pos, sprite_player, auto_played, exp_e[5:2], exp_e[1], exp_e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_game();
    rst = 1'b1; cyc(1); rst = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    exp_player = 1'b0;
  endtask

  // Legal move from WAIT_MOVE; returns four cycles later in WAIT_MOVE or GAME_OVER.
  task automatic play(input logic [3:0] pos);
    exp_q.push_back({pos, exp_player, 1'b0});
    move_valid = 1'b1; move_pos = pos; cyc(1); move_valid = 1'b0;
    cyc(3);
    exp_player = ~exp_player;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
    checks++; if (board_x !== 9'h0 || board_o !== 9'h0) begin errors++;
      $display("FAIL reset_boards: got x=%h o=%h, required 0 0", board_x, board_o); end
    checks++; if (player !== 1'b0) begin errors++;
      $display("FAIL reset_player: got %0d, required 0", player); end
    checks++; if (time_left !== 5'd3) begin errors++;
      $display("FAIL reset_time: got %0d, required 3", time_left); end
    checks++; if (winner !== 2'b00 || print_win !== 1'b0) begin errors++;
      $display("FAIL reset_winner: got w=%b pw=%b, required 00 0", winner, print_win); end
    checks++; if ({invalid_move, print_sprite, auto_played, sprite_pos, sprite_player} !== 8'h0)
      begin errors++;
      $display("FAIL reset_pulses: got inv=%b spr=%b auto=%b pos=%0d sp=%b, required all 0",
               invalid_move, print_sprite, auto_played, sprite_pos, sprite_player); end
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    checks++; if (time_left !== 5'd2) begin errors++;
      $display("FAIL start_countdown: got %0d, required 2", time_left); end
  endtask

  task automatic test_x_win();
    new_game();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
    checks++; if (board_x !== 9'h007 || board_o !== 9'h018) begin errors++;
      $display("FAIL xwin_boards: got x=%h o=%h, required 007 018", board_x, board_o); end
    checks++; if (winner !== 2'b01 || print_win !== 1'b1) begin errors++;
      $display("FAIL xwin_winner: got w=%b pw=%b, required 01 1", winner, print_win); end
    move_valid = 1'b1; move_pos = 4'd5; cyc(1); move_valid = 1'b0; cyc(4);
    checks++; if (board_o !== 9'h018 || winner !== 2'b01 || print_win !== 1'b1) begin errors++;
      $display("FAIL gameover_frozen: got o=%h w=%b pw=%b, required 018 01 1",
               board_o, winner, print_win); end
    start = 1'b1; cyc(1); start = 1'b0;
    checks++; if (board_x !== 9'h0 || board_o !== 9'h0 || winner !== 2'b00 || print_win !== 1'b0)
      begin errors++;
      $display("FAIL restart: got x=%h o=%h w=%b pw=%b, required 0 0 00 0",
               board_x, board_o, winner, print_win); end
  endtask

  task automatic test_illegal();
    new_game();
    play(4'd4);
    move_valid = 1'b1; move_pos = 4'd4; cyc(1); move_valid = 1'b0;
    checks++; if (invalid_move !== 1'b1) begin errors++;
      $display("FAIL occupied_reject: got inv=%b, required 1", invalid_move); end
    cyc(1);
    checks++; if (invalid_move !== 1'b0 || player !== 1'b1 || board_o !== 9'h0) begin errors++;
      $display("FAIL occupied_after: got inv=%b player=%b o=%h, required 0 1 000",
               invalid_move, player, board_o); end
    move_valid = 1'b1; move_pos = 4'd9; cyc(1); move_valid = 1'b0;
    checks++; if (invalid_move !== 1'b1) begin errors++;
      $display("FAIL range_reject: got inv=%b, required 1", invalid_move); end
    cyc(1);
    play(4'd5);
    checks++; if (board_o !== 9'h020 || board_x !== 9'h010 || player !== 1'b0) begin errors++;
      $display("FAIL legal_after_reject: got x=%h o=%h player=%b, required 010 020 0",
               board_x, board_o, player); end
  endtask

  task automatic test_timeout();
    new_game();
    rand_pos = 4'd0;
    play(4'd0);
    checks++; if (time_left !== 5'd3) begin errors++;
      $display("FAIL timeout_t3: got %0d, required 3", time_left); end
    cyc(4);
    checks++; if (time_left !== 5'd2) begin errors++;
      $display("FAIL timeout_t2: got %0d, required 2", time_left); end
    cyc(4);
    checks++; if (time_left !== 5'd1 || print_sprite !== 1'b0) begin errors++;
      $display("FAIL timeout_t1: got t=%0d spr=%b, required 1 0", time_left, print_sprite); end
    exp_q.push_back({4'd1, 1'b1, 1'b1});
    cyc(4);
    checks++; if (print_sprite !== 1'b1 || auto_played !== 1'b1 || time_left !== 5'd0) begin
      errors++;
      $display("FAIL timeout_fire: got spr=%b auto=%b t=%0d, required 1 1 0",
               print_sprite, auto_played, time_left); end
    cyc(1);
    checks++; if (board_o !== 9'h002 || auto_played !== 1'b0) begin errors++;
      $display("FAIL timeout_board: got o=%h auto=%b, required 002 0", board_o, auto_played); end
    cyc(1);
    exp_player = 1'b0;
  endtask

  task automatic test_tie();
    new_game();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4);
    play(4'd3); play(4'd5); play(4'd7); play(4'd6);
    checks++; if (winner !== 2'b00 || print_win !== 1'b0) begin errors++;
      $display("FAIL tie_premature: got w=%b pw=%b, required 00 0", winner, print_win); end
    play(4'd8);
    checks++; if (winner !== 2'b11 || print_win !== 1'b1 || (board_x | board_o) !== 9'h1ff)
      begin errors++;
      $display("FAIL tie: got w=%b pw=%b occ=%h, required 11 1 1ff",
               winner, print_win, board_x | board_o); end
  endtask

  task automatic test_back_to_back();
    new_game();
    rand_pos = 4'd0;
    play(4'd0);
    cyc(11);
    play(4'd8);
    checks++; if (board_o !== 9'h100 || player !== 1'b0 || time_left !== 5'd3) begin errors++;
      $display("FAIL move_vs_timeout: got o=%h player=%b t=%0d, required 100 0 3",
               board_o, player, time_left); end
  endtask

  task automatic test_reset_in_check_win();
    new_game();
    exp_q.push_back({4'd0, 1'b0, 1'b0});
    move_valid = 1'b1; move_pos = 4'd0; cyc(1); move_valid = 1'b0;
    cyc(2);
    checks++; if (board_x !== 9'h001) begin errors++;
      $display("FAIL checkwin_board: got x=%h, required 001", board_x); end
    rst = 1'b1; cyc(1); rst = 1'b0;
    checks++; if (board_x !== 9'h0 || board_o !== 9'h0 || player !== 1'b0) begin errors++;
      $display("FAIL rst_checkwin: got x=%h o=%h player=%b, required 0 0 0",
               board_x, board_o, player); end
    cyc(4);
    checks++; if (time_left !== 5'd3 || print_win !== 1'b0) begin errors++;
      $display("FAIL rst_idle: got t=%0d pw=%b, required 3 0", time_left, print_win); end
  endtask

  initial begin
    test_reset();
    test_x_win();
    test_illegal();
    test_timeout();
    test_tie();
    test_back_to_back();
    test_reset_in_check_win();
    cyc(2);
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: got %0d pending placements, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tictactoe_turn_controller.md
Name: tictactoe_turn_controller

Overview:
- Central sequencer for the tic-tac-toe game: owns the two board bitmaps (X, O), alternates turns, and runs a per-turn countdown.
- Checks that each submitted move is legal, applies it, and checks for a win or tie after every placement.
- On timeout it auto-plays a free cell seeded by an external random source.
- Sits between the player-input logic and the display/sprite printer; drives print strobes and the winner status.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown tick (1 s at 50 MHz); min 2
TURN_TIMEOUT, 15, ticks allowed per turn; range 1..31

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin new game; honoured only in IDLE or GAME_OVER
move_valid  input  1  one-cycle strobe: player submitted move_pos
move_pos  input  4  cell index 0..8, row-major
rand_pos  input  4  random seed cell, sampled on timeout
player  output  1  current turn, 0=X, 1=O
time_left  output  5  remaining ticks in current turn
board_x  output  9  cells held by X, bit i = cell i
board_o  output  9  cells held by O
invalid_move  output  1  one-cycle pulse: rejected move
print_sprite  output  1  one-cycle pulse: draw sprite
sprite_pos  output  4  cell of last placement, valid with print_sprite
sprite_player  output  1  owner of last placement
auto_played  output  1  one-cycle pulse with print_sprite when placement came from timeout
print_win  output  1  held high in GAME_OVER
winner  output  2  00 none, 01 X, 10 O, 11 tie

Behaviour:
- Reset and IDLE:
  - rst=1 overrides everything, in any state.
  - Next state is IDLE; boards=0, player=0, time_left=TURN_TIMEOUT, prescaler=0, winner=00.
  - All pulse outputs are 0, as are print_win, sprite_pos and sprite_player.
- States: IDLE, WAIT_MOVE, VALIDATE, APPLY, CHECK_WIN, GAME_OVER.
- IDLE or GAME_OVER with start=1:
  - Clear boards and winner; set player=0, time_left=TURN_TIMEOUT, prescaler=0.
  - Go to WAIT_MOVE next cycle.
  - move_valid is ignored in both states.
- WAIT_MOVE countdown:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At each wrap (tick), time_left decrements.
- WAIT_MOVE timeout:
  - A tick with time_left==1 sets time_left to 0 and raises timeout.
  - Target cell = first free cell scanning upward from rand_pos with wrap 8->0; rand_pos>8 is treated as 0.
  - Go to APPLY with auto flag set.
- WAIT_MOVE move: move_valid=1 captures move_pos and goes to VALIDATE.
- Move and timeout in the same cycle: the move wins and the timeout is discarded.
- A tick is suppressed while the FSM is outside WAIT_MOVE.
- VALIDATE:
  - Reject if pos>8 or (board_x|board_o)[pos]=1.
  - On reject: invalid_move pulses for 1 cycle and the FSM returns to WAIT_MOVE. time_left and prescaler are kept, not reloaded.
  - Otherwise go to APPLY.
- APPLY:
  - Set bit pos in the current player's board.
  - Pulse print_sprite with sprite_pos=pos and sprite_player=player; auto_played=auto.
  - Go to CHECK_WIN.
- CHECK_WIN: evaluate the 8 lines on the updated board of the current player (rows 012/345/678, columns 036/147/258, diagonals 048/246).
  - Win: winner=01 (X) or 10 (O); go to GAME_OVER.
  - Else if all 9 cells are occupied: winner=11; go to GAME_OVER.
  - Else: toggle player, set time_left=TURN_TIMEOUT, prescaler=0; go to WAIT_MOVE.
- Latency: a move accepted in cycle N has VALIDATE at N+1 and APPLY at N+2. The board change is visible at N+3. WAIT_MOVE (next player) or GAME_OVER is reached at N+4.
- GAME_OVER: print_win=1 and winner is held until start or rst; boards are frozen.
- Invariant: a free cell always exists in WAIT_MOVE, so the timeout scan always terminates within 9 cells.

Test Plan (TICK_DIV=4, TURN_TIMEOUT=3):
1. Reset: assert rst for 2 cycles -> boards=0, player=0, time_left=3, winner=00, all pulses 0; start -> WAIT_MOVE.
2. X win: X0, O3, X1, O4, X2 -> board_x=0x007, board_o=0x018, winner=01, print_win=1; a further move_valid is ignored.
3. Illegal move: X4, then O4 -> one invalid_move pulse, player stays 1, board_o=0; O9 -> also rejected; O5 accepted.
4. Timeout: X0 played; O idle with rand_pos=0 -> time_left reads 3,2,1 and auto-play fires 12 cycles after WAIT_MOVE entry; sprite_pos=1, auto_played=1, board_o=0x002.
5. Tie: X0 O1 X2 O4 X3 O5 X7 O6 X8 -> winner=11 after the 9th placement, print_win=1.
6. Boundary cases:
   - move_valid on the same cycle as the timeout tick, pos=8 -> cell 8 placed, auto_played=0.
   - rst asserted during CHECK_WIN -> IDLE next cycle, boards=0.
